avr_spi_slave: RTL and testbench

//   SPI slave (mode 0, MSB first) for the AVR link. It is the direct consumer of the

---
 rtl/avr_spi_slave.sv | 165 ++++++++++++++++
 tb/tb_avr_spi_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_spi_slave.sv
// SPI mode-0 slave for the AVR link, gated by the cclk detector's ready level.
// Pins are synchronised into clk; bytes shift MSB first in both directions.
`timescale 1ns/1ps
module avr_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    DISABLED,
    WAIT_SS_HIGH,
    IDLE,
    SHIFT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_last;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [2:0] bit_ctr;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic [7:0] hold;
  logic       full;
  logic       reload;
  logic       miso_q;
  logic       oe_q;
  logic       accept;
  logic [7:0] next_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= '0;
      ss_q     <= '1;
      mosi_q   <= '0;
      sck_last <= 1'b0;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q     <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_last <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_last;
  assign sck_fall = ~sck_s & sck_last;

  assign tx_ready  = ready & (state != DISABLED) & ~full;
  assign accept    = tx_valid & tx_ready;
  assign next_byte = full ? hold : IDLE_BYTE;

  // ready gates the pad enable combinationally so it drops without delay
  assign miso_oe = oe_q & ready;
  assign miso    = miso_q & miso_oe;
  assign busy    = (state == SHIFT) & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DISABLED;
      bit_ctr  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 7'd0;
      hold     <= 8'h00;
      full     <= 1'b0;
      reload   <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        hold <= tx_data;
        full <= 1'b1;
      end
      if (!ready) begin
        state    <= DISABLED;
        bit_ctr  <= 3'd0;
        rx_shift <= 7'd0;
        tx_shift <= 7'd0;
        full     <= 1'b0;
        reload   <= 1'b0;
        miso_q   <= 1'b0;
        oe_q     <= 1'b0;
      end else begin
        unique case (state)
          DISABLED: begin
            state <= WAIT_SS_HIGH;
          end
          WAIT_SS_HIGH: begin
            if (ss_s) state <= IDLE;
          end
          IDLE: begin
            if (!ss_s) begin
              tx_shift <= next_byte[6:0];
              miso_q   <= next_byte[7];
              if (full) full <= 1'b0;
              bit_ctr  <= 3'd0;
              rx_shift <= 7'd0;
              reload   <= 1'b0;
              oe_q     <= 1'b1;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            // ss abort takes priority over a coincident sck edge
            if (ss_s) begin
              bit_ctr <= 3'd0;
              reload  <= 1'b0;
              miso_q  <= 1'b0;
              oe_q    <= 1'b0;
              state   <= IDLE;
            end else if (sck_rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              if (bit_ctr == 3'd7) begin
                rx_data  <= {rx_shift, mosi_s};
                rx_valid <= 1'b1;
                bit_ctr  <= 3'd0;
                reload   <= 1'b1;
              end else begin
                bit_ctr <= bit_ctr + 3'd1;
              end
            end else if (sck_fall) begin
              if (bit_ctr == 3'd0 && reload) begin
                tx_shift <= next_byte[6:0];
                miso_q   <= next_byte[7];
                if (full) full <= 1'b0;
                reload   <= 1'b0;
              end else begin
                miso_q   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avr_spi_slave.sv
// Bench for avr_spi_slave: directed scenarios then random frames,
// checked against a one-deep holding-register model of the link.
`timescale 1ns/1ps
module tb_avr_spi_slave;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  avr_spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         long_strobes = 0;
  int         oe_cnt = 0;
  bit         rv_prev = 1'b0;
  logic [7:0] rx_got[$];
  logic [7:0] hold_q[$];
  logic [7:0] mo_a[4];
  logic [7:0] pv_a[4];
  bit         pe_a[4];

  // rx strobe log, strobe-length and pad-enable watch
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_got.push_back(rx_data);
      if (rv_prev) long_strobes++;
    end
    rv_prev = rx_valid;
    if (miso_oe) oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] load_byte();
    if (hold_q.size() != 0) return hold_q.pop_front();
    return 8'hFF;
  endfunction

  task automatic push_tx(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    hold_q.push_back(v);
  endtask

  task automatic sck_bits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom);
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] mo, input bit pe,
                          input logic [7:0] pv, output logic [7:0] mi);
    int miss = 0;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      #HALF sck = 1'b1;
      mi[i] = miso;
      if (!miso_oe || !busy) miss++;
      #HALF sck = 1'b0;
      if (pe && i == 4) push_tx(pv);
    end
    chk("oe_busy_in_frame", 32'(miss), 32'd0);
  endtask

  task automatic frame(input int n);
    int         base;
    logic [7:0] got;
    logic [7:0] exp;
    base = rx_got.size();
    ss = 1'b0;
    #HALF;
    for (int k = 0; k < n; k++) begin
      exp = load_byte();
      spi_byte(mo_a[k], pe_a[k], pv_a[k], got);
      chk("miso_byte", 32'(got), 32'(exp));
    end
    // the reload after the final byte consumes the holding register
    void'(load_byte());
    #HALF ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("rx_count", 32'(rx_got.size() - base), 32'(n));
    for (int k = 0; k < n; k++)
      if (base + k < rx_got.size())
        chk("rx_byte", 32'(rx_got[base+k]), 32'(mo_a[k]));
    chk("tx_ready_after", 32'(tx_ready), 32'(hold_q.size() == 0));
    chk("strobe_one_cycle", 32'(long_strobes), 32'd0);
  endtask

  initial begin
    int base;
    int oe0;
    rst      = 1'b1;
    ready    = 1'b0;
    ss       = 1'b1;
    sck      = 1'b0;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    foreach (pe_a[k]) begin
      pe_a[k] = 1'b0;
      mo_a[k] = 8'h00;
      pv_a[k] = 8'h00;
    end
    #1;
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: disabled block ignores pin activity
    base = rx_got.size();
    oe0  = oe_cnt;
    ss = 1'b0;
    #HALF;
    sck_bits(8);
    #HALF ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("dis_oe", 32'(oe_cnt - oe0), 32'd0);
    chk("dis_tx_ready", 32'(tx_ready), 32'd0);
    chk("dis_rx", 32'(rx_got.size() - base), 32'd0);
    chk("dis_miso", 32'(miso), 32'd0);

    // 2: single byte exchange
    ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("en_tx_ready", 32'(tx_ready), 32'd1);
    push_tx(8'hA5);
    chk("full_tx_ready", 32'(tx_ready), 32'd0);
    mo_a[0] = 8'h3C;
    frame(1);
    chk("rx_data_3c", 32'(rx_data), 32'h3C);

    // 3: back-to-back bytes with the second queued mid-byte
    push_tx(8'h01);
    mo_a[0] = 8'hF0;
    mo_a[1] = 8'h0F;
    pe_a[0] = 1'b1;
    pv_a[0] = 8'h80;
    frame(2);
    pe_a[0] = 1'b0;

    // 4: underrun returns the idle byte
    mo_a[0] = 8'h5A;
    frame(1);

    // 5: partial frame loses its tx byte but keeps the holding register
    push_tx(8'h77);
    base = rx_got.size();
    ss = 1'b0;
    #HALF;
    void'(load_byte());
    sck_bits(3);
    push_tx(8'h12);
    sck_bits(2);
    #HALF ss = 1'b1;
    repeat (10) @(negedge clk);
    chk("partial_no_rx", 32'(rx_got.size() - base), 32'd0);
    chk("partial_hold_kept", 32'(tx_ready), 32'd0);
    mo_a[0] = 8'h55;
    frame(1);

    // 6: ready drops mid-byte, returns while ss is still low
    ss = 1'b0;
    #HALF;
    void'(load_byte());
    sck_bits(3);
    push_tx(8'h44);
    ready = 1'b0;
    #1;
    chk("drop_oe_now", 32'(miso_oe), 32'd0);
    chk("drop_miso", 32'(miso), 32'd0);
    hold_q.delete();
    sck_bits(2);
    repeat (5) @(negedge clk);
    ready = 1'b1;
    base = rx_got.size();
    oe0  = oe_cnt;
    sck_bits(8);
    #HALF;
    chk("wait_oe", 32'(oe_cnt - oe0), 32'd0);
    chk("wait_rx", 32'(rx_got.size() - base), 32'd0);
    chk("wait_busy", 32'(busy), 32'd0);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    mo_a[0] = 8'hC3;
    frame(1);

    // random frames against the holding-register model
    for (int f = 0; f < 20; f++) begin
      int n;
      n = int'($urandom_range(1, 3));
      if (hold_q.size() == 0 && $urandom_range(0, 1) == 1)
        push_tx(8'($urandom));
      for (int k = 0; k < n; k++) begin
        mo_a[k] = 8'($urandom);
        pe_a[k] = 1'($urandom);
        pv_a[k] = 8'($urandom);
      end
      frame(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
